instr_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the CPU core. Owns the program counter and drives
//  the word address of an external synchronous instruction ROM with 1-cycle read latency (prgrom).

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_target_calc.sv | 24 ++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: redirect kinds, FSM states, PC step.
package fetch_pkg;

  localparam logic [1:0] RK_REL_WORD = 2'd0;
  localparam logic [1:0] RK_ABS_REG  = 2'd1;
  localparam logic [1:0] RK_TRAP     = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_target_calc.sv
// Redirect target arithmetic: relative word branch, aligned register jump, or trap vector.
module fetch_target_calc
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic [1:0]      redirect_kind,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_offset,
  output logic [XLEN-1:0] target
);

  always_comb begin
    target = TRAP_VEC;
    case (redirect_kind)
      RK_REL_WORD: target = redirect_base + (redirect_offset << 2);
      RK_ABS_REG:  target = (redirect_base + redirect_offset) & ~XLEN'(3);
      // RK_TRAP and the reserved encoding both vector to the trap handler
      default:     target = TRAP_VEC;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency ROM and presents PC/instruction
// pairs to decode with a stall handshake and a one-entry hold buffer.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ADDR_BITS = 14,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [1:0]           redirect_kind,
  input  logic [XLEN-1:0]      redirect_base,
  input  logic [XLEN-1:0]      redirect_offset,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [31:0]          rom_data,
  output logic                 if_valid,
  output logic [XLEN-1:0]      if_pc,
  output logic [XLEN-1:0]      if_pc_plus4,
  output logic [31:0]          if_instr,
  output logic [31:0]          fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_issue_q, pc_issue_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_next;

  fetch_target_calc #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_target_calc (
    .redirect_kind   (redirect_kind),
    .redirect_base   (redirect_base),
    .redirect_offset (redirect_offset),
    .target          (target)
  );

  assign pc_next     = pc_issue_q + XLEN'(PC_INC);
  assign rom_addr    = pc_issue_q[ADDR_BITS+1:2];
  assign if_pc       = out_pc_q;
  assign if_pc_plus4 = out_pc_q + XLEN'(PC_INC);
  assign fetch_count = fetch_count_q;

  always_comb begin
    state_d      = state_q;
    pc_issue_d   = pc_issue_q;
    out_pc_d     = out_pc_q;
    hold_instr_d = hold_instr_q;
    if_valid     = 1'b0;
    if_instr     = '0;

    case (state_q)
      S_EMPTY: begin
        if (redirect_valid) begin
          pc_issue_d = target;
        end else begin
          state_d    = S_RUN;
          out_pc_d   = pc_issue_q;
          pc_issue_d = pc_next;
        end
      end
      S_RUN: begin
        if_valid = !redirect_valid;
        if_instr = rom_data;
        if (redirect_valid) begin
          state_d    = S_EMPTY;
          pc_issue_d = target;
        end else if (stall) begin
          // ROM output moves on next cycle, so capture the presented word now
          state_d      = S_HOLD;
          hold_instr_d = rom_data;
        end else begin
          out_pc_d   = pc_issue_q;
          pc_issue_d = pc_next;
        end
      end
      S_HOLD: begin
        if_valid = !redirect_valid;
        if_instr = hold_instr_q;
        if (redirect_valid) begin
          state_d    = S_EMPTY;
          pc_issue_d = target;
        end else if (!stall) begin
          // pc_issue was parked during the stall, so rom_data already holds its word
          state_d    = S_RUN;
          out_pc_d   = pc_issue_q;
          pc_issue_d = pc_next;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    fetch_count_d = fetch_count_q + ((if_valid && !stall) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_EMPTY;
      pc_issue_q    <= RESET_PC;
      out_pc_q      <= '0;
      hold_instr_q  <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_issue_q    <= pc_issue_d;
      out_pc_q      <= out_pc_d;
      hold_instr_q  <= hold_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table plus hand sequences for wrap and reset.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_base;
  logic [31:0] redirect_offset;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic [31:0] fetch_count;

  logic [13:0] w_rom_addr;
  logic [31:0] w_rom_data;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_pc_plus4;
  logic [31:0] w_if_instr;
  logic [31:0] w_fetch_count;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_kind   (redirect_kind),
    .redirect_base   (redirect_base),
    .redirect_offset (redirect_offset),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instr        (if_instr),
    .fetch_count     (fetch_count)
  );

  instr_fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_w (
    .clk             (clk),
    .reset           (reset),
    .stall           (1'b0),
    .redirect_valid  (1'b0),
    .redirect_kind   (2'd0),
    .redirect_base   (32'd0),
    .redirect_offset (32'd0),
    .rom_addr        (w_rom_addr),
    .rom_data        (w_rom_data),
    .if_valid        (w_if_valid),
    .if_pc           (w_if_pc),
    .if_pc_plus4     (w_if_pc_plus4),
    .if_instr        (w_if_instr),
    .fetch_count     (w_fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word[i] = A000_0000 | i, one cycle read latency
  always @(posedge clk) begin
    rom_data   <= 32'hA000_0000 | {18'd0, rom_addr};
    w_rom_data <= 32'hA000_0000 | {18'd0, w_rom_addr};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        stall;
    logic        rv;
    logic [1:0]  kind;
    logic [31:0] base;
    logic [31:0] off;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_count;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic st, input logic rv, input logic [1:0] k,
                              input logic [31:0] b, input logic [31:0] o, input logic v,
                              input logic cd, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] cnt);
    vec_t r;
    r = '{stall: st, rv: rv, kind: k, base: b, off: o, exp_valid: v, chk_data: cd,
          exp_pc: pc, exp_instr: ins, exp_count: cnt};
    return r;
  endfunction

  initial begin
    //            st rv k  base      off  valid chk pc         instr          count
    vecs[0]  = mk(0, 0, 0, 0,        0,   0, 1, 32'h0,   32'h0,         0);
    vecs[1]  = mk(0, 0, 0, 0,        0,   1, 1, 32'h0,   32'hA000_0000, 0);
    vecs[2]  = mk(0, 0, 0, 0,        0,   1, 1, 32'h4,   32'hA000_0001, 1);
    vecs[3]  = mk(1, 0, 0, 0,        0,   1, 1, 32'h8,   32'hA000_0002, 2);
    vecs[4]  = mk(1, 0, 0, 0,        0,   1, 1, 32'h8,   32'hA000_0002, 2);
    vecs[5]  = mk(1, 0, 0, 0,        0,   1, 1, 32'h8,   32'hA000_0002, 2);
    vecs[6]  = mk(0, 0, 0, 0,        0,   1, 1, 32'h8,   32'hA000_0002, 2);
    vecs[7]  = mk(0, 0, 0, 0,        0,   1, 1, 32'hC,   32'hA000_0003, 3);
    vecs[8]  = mk(0, 1, 0, 32'h10,   3,   0, 1, 32'h10,  32'hA000_0004, 4);
    vecs[9]  = mk(0, 0, 0, 0,        0,   0, 0, 32'h0,   32'h0,         4);
    vecs[10] = mk(0, 0, 0, 0,        0,   1, 1, 32'h1C,  32'hA000_0007, 4);
    vecs[11] = mk(1, 1, 1, 32'h100,  7,   0, 1, 32'h20,  32'hA000_0008, 5);
    vecs[12] = mk(0, 0, 0, 0,        0,   0, 0, 32'h0,   32'h0,         5);
    vecs[13] = mk(0, 0, 0, 0,        0,   1, 1, 32'h104, 32'hA000_0041, 5);
    vecs[14] = mk(0, 1, 3, 32'h5000, 9,   0, 1, 32'h108, 32'hA000_0042, 6);
    vecs[15] = mk(0, 0, 0, 0,        0,   0, 0, 32'h0,   32'h0,         6);
    vecs[16] = mk(0, 0, 0, 0,        0,   1, 1, 32'h100, 32'hA000_0040, 6);
    vecs[17] = mk(1, 0, 0, 0,        0,   1, 1, 32'h104, 32'hA000_0041, 7);
    vecs[18] = mk(1, 1, 2, 32'h40,   1,   0, 1, 32'h104, 32'hA000_0041, 7);
    vecs[19] = mk(0, 0, 0, 0,        0,   0, 0, 32'h0,   32'h0,         7);
    vecs[20] = mk(1, 0, 0, 0,        0,   1, 1, 32'h100, 32'hA000_0040, 7);
    vecs[21] = mk(1, 0, 0, 0,        0,   1, 1, 32'h100, 32'hA000_0040, 7);

    reset           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_kind   = 2'd0;
    redirect_base   = '0;
    redirect_offset = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_rom_addr", {18'd0, rom_addr}, 32'd0);
    check("rst_w_rom_addr", {18'd0, w_rom_addr}, 32'h3FFE);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      stall           = vecs[i].stall;
      redirect_valid  = vecs[i].rv;
      redirect_kind   = vecs[i].kind;
      redirect_base   = vecs[i].base;
      redirect_offset = vecs[i].off;
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_pc", i), if_pc, vecs[i].exp_pc);
        check($sformatf("v%0d_pc4", i), if_pc_plus4, vecs[i].exp_pc + 32'd4);
        check($sformatf("v%0d_instr", i), if_instr, vecs[i].exp_instr);
      end
      check($sformatf("v%0d_count", i), fetch_count, vecs[i].exp_count);

      // Wrapping instance runs stall-free alongside the first few vectors
      case (i)
        0: begin
          check("w0_valid", {31'd0, w_if_valid}, 32'd0);
          check("w0_rom_addr", {18'd0, w_rom_addr}, 32'h3FFE);
        end
        1: begin
          check("w1_pc", w_if_pc, 32'hFFFF_FFF8);
          check("w1_instr", w_if_instr, 32'hA000_3FFE);
          check("w1_rom_addr", {18'd0, w_rom_addr}, 32'h3FFF);
        end
        2: begin
          check("w2_pc", w_if_pc, 32'hFFFF_FFFC);
          check("w2_pc4", w_if_pc_plus4, 32'h0);
          check("w2_instr", w_if_instr, 32'hA000_3FFF);
          check("w2_rom_addr", {18'd0, w_rom_addr}, 32'h0);
        end
        3: begin
          check("w3_valid", {31'd0, w_if_valid}, 32'd1);
          check("w3_pc", w_if_pc, 32'h0);
          check("w3_instr", w_if_instr, 32'hA000_0000);
          check("w3_count", w_fetch_count, 32'd2);
        end
        default: ;
      endcase

      @(posedge clk);
      @(negedge clk);
    end

    // DUT sits in S_HOLD here; asynchronous reset must clear it between clock edges
    check("hold_before_rst", {31'd0, if_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, if_valid}, 32'd0);
    check("async_rst_pc", if_pc, 32'd0);
    check("async_rst_instr", if_instr, 32'd0);
    check("async_rst_count", fetch_count, 32'd0);
    check("async_rst_rom_addr", {18'd0, rom_addr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
